// File: rtl/wand_ir_pkg.sv
// Shared types and timing windows for the NEC wand-trace decoder.
// All window bounds are in whole microseconds and are inclusive.
package wand_ir_pkg;

  localparam int unsigned WIDTH_W    = 14;
  localparam int unsigned FRAME_BITS = 32;
  localparam int unsigned CNT_W      = 6;
  localparam int unsigned TRACE_W    = 16;
  localparam int unsigned CELL_W     = 4;
  localparam int unsigned CMD_W      = 4;

  localparam logic [WIDTH_W-1:0] WIDTH_SAT_US    = WIDTH_W'(16383);
  localparam logic [WIDTH_W-1:0] LEAD_LOW_MIN_US = WIDTH_W'(8000);
  localparam logic [WIDTH_W-1:0] LEAD_LOW_MAX_US = WIDTH_W'(10000);
  localparam logic [WIDTH_W-1:0] LEAD_SPC_MIN_US = WIDTH_W'(4000);
  localparam logic [WIDTH_W-1:0] LEAD_SPC_MAX_US = WIDTH_W'(5000);
  localparam logic [WIDTH_W-1:0] REPEAT_MIN_US   = WIDTH_W'(2000);
  localparam logic [WIDTH_W-1:0] REPEAT_MAX_US   = WIDTH_W'(2500);
  localparam logic [WIDTH_W-1:0] BIT_MARK_MIN_US = WIDTH_W'(400);
  localparam logic [WIDTH_W-1:0] BIT_MARK_MAX_US = WIDTH_W'(700);
  localparam logic [WIDTH_W-1:0] BIT_ZERO_MIN_US = WIDTH_W'(400);
  localparam logic [WIDTH_W-1:0] BIT_ZERO_MAX_US = WIDTH_W'(700);
  localparam logic [WIDTH_W-1:0] BIT_ONE_MIN_US  = WIDTH_W'(1400);
  localparam logic [WIDTH_W-1:0] BIT_ONE_MAX_US  = WIDTH_W'(1900);
  localparam logic [WIDTH_W-1:0] TIMEOUT_US      = WIDTH_W'(12000);

  localparam logic [CMD_W-1:0] CMD_MARK  = 4'h1;
  localparam logic [CMD_W-1:0] CMD_CLEAR = 4'h2;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LEAD_LOW  = 3'd1,
    S_LEAD_HIGH = 3'd2,
    S_BIT_LOW   = 3'd3,
    S_BIT_HIGH  = 3'd4,
    S_CHECK     = 3'd5
  } ir_state_e;

  // Bits arrive LSB first, so the first byte received lands in the low byte.
  typedef struct packed {
    logic [7:0] data_n;
    logic [7:0] data;
    logic [7:0] addr_n;
    logic [7:0] addr;
  } nec_frame_t;

  function automatic logic in_window(input logic [WIDTH_W-1:0] w,
                                     input logic [WIDTH_W-1:0] lo,
                                     input logic [WIDTH_W-1:0] hi);
    return (w >= lo) && (w <= hi);
  endfunction

endpackage

// File: rtl/wand_ir_decoder_timer.sv
// Pulse timer: 1 us prescaler, ir_rx synchronizer, edge detect and a
// saturating width counter that restarts on every synchronized edge.
module ir_pulse_timer
  import wand_ir_pkg::*;
#(
  parameter int unsigned CLK_PER_US = 25
) (
  input  logic               iVGA_CLK,
  input  logic               iRST_n,
  input  logic               ir_rx,
  output logic               fall,
  output logic               rise,
  output logic [WIDTH_W-1:0] width_us
);

  localparam int unsigned PRE_W = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_PER_US - 1);

  logic [PRE_W-1:0]   pre_q;
  logic               sync1_q;
  logic               sync2_q;
  logic               prev_q;
  logic [WIDTH_W-1:0] width_q;
  logic               edge_c;
  logic               tick_c;

  // prev_q is the edge-detect stage behind the two synchronizer flops.
  assign fall     = prev_q & ~sync2_q;
  assign rise     = ~prev_q & sync2_q;
  assign edge_c   = fall | rise;
  assign tick_c   = (pre_q == PRE_LAST);
  assign width_us = width_q;

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      pre_q   <= '0;
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      width_q <= '0;
    end else begin
      sync1_q <= ir_rx;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      if (edge_c) begin
        // Restarting the prescaler keeps widths a truncated count of whole us.
        pre_q   <= '0;
        width_q <= '0;
      end else if (tick_c) begin
        pre_q <= '0;
        if (width_q != WIDTH_SAT_US) begin
          width_q <= width_q + WIDTH_W'(1);
        end
      end else begin
        pre_q <= pre_q + PRE_W'(1);
      end
    end
  end

endmodule

// File: rtl/wand_ir_decoder.sv
// NEC frame decoder for one player's wand; maintains the 4x4 traced-cell
// bitmap consumed by the display path.
module wand_ir_decoder
  import wand_ir_pkg::*;
#(
  parameter int unsigned CLK_PER_US  = 25,
  parameter logic [7:0]  PLAYER_ADDR = 8'h01
) (
  input  logic               iVGA_CLK,
  input  logic               iRST_n,
  input  logic               ir_rx,
  input  logic               clear_trace,
  output logic [TRACE_W-1:0] trace,
  output logic [CELL_W-1:0]  cell_idx,
  output logic               frame_valid,
  output logic               frame_err,
  output logic               busy
);

  logic               fall;
  logic               rise;
  logic [WIDTH_W-1:0] width_us;

  ir_state_e              state_q, state_d;
  logic [FRAME_BITS-1:0]  shift_q, shift_d;
  logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [TRACE_W-1:0]     trace_q, trace_d;
  logic [CELL_W-1:0]      cell_idx_q, cell_idx_d;
  logic                   frame_valid_q, frame_valid_d;
  logic                   frame_err_q, frame_err_d;
  logic                   busy_q, busy_d;

  nec_frame_t             frame_c;
  logic                   timeout_c;
  logic                   bit_ok_c;
  logic                   bit_val_c;

  ir_pulse_timer #(
    .CLK_PER_US (CLK_PER_US)
  ) u_timer (
    .iVGA_CLK (iVGA_CLK),
    .iRST_n   (iRST_n),
    .ir_rx    (ir_rx),
    .fall     (fall),
    .rise     (rise),
    .width_us (width_us)
  );

  assign frame_c   = nec_frame_t'(shift_q);
  assign timeout_c = (state_q != S_IDLE) && (state_q != S_CHECK) &&
                     (width_us >= TIMEOUT_US);

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q       <= S_IDLE;
      shift_q       <= '0;
      bit_cnt_q     <= '0;
      trace_q       <= '0;
      cell_idx_q    <= '0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      shift_q       <= shift_d;
      bit_cnt_q     <= bit_cnt_d;
      trace_q       <= trace_d;
      cell_idx_q    <= cell_idx_d;
      frame_valid_q <= frame_valid_d;
      frame_err_q   <= frame_err_d;
      busy_q        <= busy_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    shift_d       = shift_q;
    bit_cnt_d     = bit_cnt_q;
    trace_d       = trace_q;
    cell_idx_d    = cell_idx_q;
    frame_valid_d = 1'b0;
    frame_err_d   = 1'b0;
    bit_ok_c      = 1'b0;
    bit_val_c     = 1'b0;

    if (timeout_c) begin
      state_d     = S_IDLE;
      frame_err_d = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (fall) state_d = S_LEAD_LOW;
        end

        S_LEAD_LOW: begin
          if (rise) begin
            if (in_window(width_us, LEAD_LOW_MIN_US, LEAD_LOW_MAX_US)) begin
              state_d = S_LEAD_HIGH;
            end else begin
              state_d     = S_IDLE;
              frame_err_d = 1'b1;
            end
          end
        end

        S_LEAD_HIGH: begin
          if (fall) begin
            if (in_window(width_us, LEAD_SPC_MIN_US, LEAD_SPC_MAX_US)) begin
              state_d   = S_BIT_LOW;
              bit_cnt_d = '0;
            end else if (in_window(width_us, REPEAT_MIN_US, REPEAT_MAX_US)) begin
              state_d = S_IDLE;
            end else begin
              state_d     = S_IDLE;
              frame_err_d = 1'b1;
            end
          end
        end

        S_BIT_LOW: begin
          if (rise) begin
            if (in_window(width_us, BIT_MARK_MIN_US, BIT_MARK_MAX_US)) begin
              state_d = S_BIT_HIGH;
            end else begin
              state_d     = S_IDLE;
              frame_err_d = 1'b1;
            end
          end
        end

        S_BIT_HIGH: begin
          if (fall) begin
            if (in_window(width_us, BIT_ZERO_MIN_US, BIT_ZERO_MAX_US)) begin
              bit_ok_c = 1'b1;
            end else if (in_window(width_us, BIT_ONE_MIN_US, BIT_ONE_MAX_US)) begin
              bit_ok_c  = 1'b1;
              bit_val_c = 1'b1;
            end
            if (bit_ok_c) begin
              shift_d   = {bit_val_c, shift_q[FRAME_BITS-1:1]};
              bit_cnt_d = bit_cnt_q + CNT_W'(1);
              state_d   = (bit_cnt_q == CNT_W'(FRAME_BITS - 1)) ? S_CHECK : S_BIT_LOW;
            end else begin
              state_d     = S_IDLE;
              frame_err_d = 1'b1;
            end
          end
        end

        S_CHECK: begin
          state_d = S_IDLE;
          if ((frame_c.addr_n != ~frame_c.addr) || (frame_c.data_n != ~frame_c.data)) begin
            frame_err_d = 1'b1;
          end else if (frame_c.addr == PLAYER_ADDR) begin
            frame_valid_d = 1'b1;
            if (frame_c.data[7:4] == CMD_MARK) begin
              trace_d[frame_c.data[3:0]] = 1'b1;
              cell_idx_d                 = frame_c.data[3:0];
            end else if (frame_c.data[7:4] == CMD_CLEAR) begin
              trace_d = '0;
            end
          end
        end

        default: state_d = S_IDLE;
      endcase
    end

    // Game-logic clear wins over a mark landing in the same cycle.
    if (clear_trace) trace_d = '0;

    busy_d = (state_d != S_IDLE);
  end

  assign trace       = trace_q;
  assign cell_idx    = cell_idx_q;
  assign frame_valid = frame_valid_q;
  assign frame_err   = frame_err_q;
  assign busy        = busy_q;

endmodule
